// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing one JK flip-flop bank between NREQ requesters, one command in flight.
// Latency: accept -> done in 2 cycles (1 for out-of-range index); next accept the cycle after done.
// Backpressure: req_ready is a one-hot accept pulse only in IDLE; requests seen while busy simply wait.
module jk_bank_sched #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [2*NREQ-1:0]         req_cmd,
    input  logic [IDXW*NREQ-1:0]      req_idx,
    output logic [NFF-1:0]            ff_en,
    output logic [NFF-1:0]            ff_j,
    output logic [NFF-1:0]            ff_k,
    input  logic [NFF-1:0]            ff_q,
    output logic                      done_valid,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic                      done_q,
    output logic                      done_err,
    output logic                      busy
);
    localparam int IDW  = $clog2(NREQ);
    localparam int NPAD = 2**IDXW;
    localparam logic [IDXW:0] NFF_W = (IDXW+1)'(NFF);

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_SET    = 2'b01;
    localparam logic [1:0] CMD_RESET  = 2'b10;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    ptr, ptr_nxt;
    logic [1:0]        cmd_r;
    logic [IDXW-1:0]   idx_r;
    logic [IDW-1:0]    id_r;
    logic              prev_r;

    logic              gnt_vld;
    logic [IDW-1:0]    gnt_id;
    logic [1:0]        gnt_cmd;
    logic [IDXW-1:0]   gnt_idx;
    logic              gnt_in_range;
    logic              in_range_r;
    logic              exp_q;
    logic [NPAD-1:0]   q_pad;
    logic [NPAD-1:0]   sel_pad;
    int                cand;

    // Zero-padding the bank to 2**IDXW makes out-of-range reads return 0 with no extra muxing.
    assign q_pad        = NPAD'(ff_q);
    assign sel_pad      = NPAD'(1) << idx_r;
    assign gnt_in_range = {1'b0, gnt_idx} < NFF_W;
    assign in_range_r   = {1'b0, idx_r} < NFF_W;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_vld && req_valid[IDW'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(cand);
            end
        end
    end

    always_comb begin
        gnt_cmd = '0;
        gnt_idx = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_id == IDW'(r)) begin
                gnt_cmd = req_cmd[2*r +: 2];
                gnt_idx = req_idx[IDXW*r +: IDXW];
            end
        end
        ptr_nxt = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            cmd_r  <= '0;
            idx_r  <= '0;
            id_r   <= '0;
            prev_r <= 1'b0;
        end else if (state == IDLE && gnt_vld) begin
            ptr    <= ptr_nxt;
            cmd_r  <= gnt_cmd;
            idx_r  <= gnt_idx;
            id_r   <= gnt_id;
            prev_r <= q_pad[gnt_idx];
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = gnt_in_range ? APPLY : CHECK;
            APPLY:   state_nxt = CHECK;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        ff_en      = '0;
        ff_j       = '0;
        ff_k       = '0;
        done_valid = 1'b0;
        done_id    = '0;
        done_q     = 1'b0;
        done_err   = 1'b0;
        busy       = (state != IDLE);
        case (cmd_r)
            CMD_HOLD:  exp_q = prev_r;
            CMD_SET:   exp_q = 1'b1;
            CMD_RESET: exp_q = 1'b0;
            default:   exp_q = ~prev_r;
        endcase
        case (state)
            IDLE: if (gnt_vld && !rst) req_ready[gnt_id] = 1'b1;
            APPLY: begin
                // cmd bit 0 drives J and bit 1 drives K
                ff_en = sel_pad[NFF-1:0];
                ff_j  = cmd_r[0] ? sel_pad[NFF-1:0] : '0;
                ff_k  = cmd_r[1] ? sel_pad[NFF-1:0] : '0;
            end
            CHECK: begin
                done_valid = 1'b1;
                done_id    = id_r;
                done_q     = q_pad[idx_r];
                done_err   = !in_range_r || (q_pad[idx_r] != exp_q);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed command table, hand-written corner sequences, then random traffic
// checked against a transaction-level model of the arbiter and flip-flop bank.
module tb_jk_bank_sched;
    localparam int NREQ = 4;
    localparam int NFF  = 6;
    localparam int IDXW = 3;
    localparam logic [1:0] C_HOLD = 2'b00, C_SET = 2'b01, C_RESET = 2'b10, C_TOG = 2'b11;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [2*NREQ-1:0]      req_cmd;
    logic [IDXW*NREQ-1:0]   req_idx;
    logic [NFF-1:0]         ff_en, ff_j, ff_k, ff_q;
    logic                   done_valid, done_q, done_err, busy;
    logic [1:0]             done_id;

    logic [NFF-1:0]         bank_q;
    logic [NFF-1:0]         stuck_mask = '0;

    int tests = 0;
    int fails = 0;

    jk_bank_sched #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_idx(req_idx),
        .ff_en(ff_en), .ff_j(ff_j), .ff_k(ff_k), .ff_q(ff_q),
        .done_valid(done_valid), .done_id(done_id), .done_q(done_q),
        .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank; stuck_mask forces selected outputs low to model a broken flop.
    always @(posedge clk) begin
        if (rst) bank_q <= '0;
        else begin
            for (int i = 0; i < NFF; i++) begin
                if (ff_en[i]) begin
                    case ({ff_j[i], ff_k[i]})
                        2'b10:   bank_q[i] <= 1'b1;
                        2'b01:   bank_q[i] <= 1'b0;
                        2'b11:   bank_q[i] <= ~bank_q[i];
                        default: bank_q[i] <= bank_q[i];
                    endcase
                end
            end
        end
    end
    assign ff_q = bank_q & ~stuck_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic next_q(input logic [1:0] c, input logic p);
        case (c)
            C_HOLD:  return p;
            C_SET:   return 1'b1;
            C_RESET: return 1'b0;
            default: return ~p;
        endcase
    endfunction

    // Called at posedge+1 with the scheduler idle; one requester issues one command.
    task automatic run_cmd(input int r, input logic [1:0] cmd, input logic [2:0] idx,
                           input logic exp_q, input logic exp_err);
        logic [7:0]      sel8;
        logic [NREQ-1:0] oh;
        logic            ej, ek;
        sel8 = 8'd1 << idx;
        ej   = (cmd == C_SET) || (cmd == C_TOG);
        ek   = (cmd == C_RESET) || (cmd == C_TOG);
        oh   = '0;
        oh[r] = 1'b1;
        req_valid = oh;
        req_cmd[2*r +: 2] = cmd;
        req_idx[IDXW*r +: IDXW] = idx;
        #1;
        chk("accept_ready", req_ready, oh);
        chk("accept_busy", busy, 0);
        @(posedge clk); #1;
        req_valid = '0;
        if (idx < NFF) begin
            chk("apply_en", ff_en, sel8[NFF-1:0]);
            chk("apply_j", ff_j, ej ? sel8[NFF-1:0] : '0);
            chk("apply_k", ff_k, ek ? sel8[NFF-1:0] : '0);
            chk("apply_no_done", done_valid, 0);
            @(posedge clk); #1;
        end
        chk("check_en", ff_en, 0);
        chk("done_valid", done_valid, 1);
        chk("done_id", done_id, r);
        chk("done_q", done_q, exp_q);
        chk("done_err", done_err, exp_err);
        @(posedge clk); #1;
        chk("back_idle", busy, 0);
    endtask

    typedef struct {
        int         r;
        logic [1:0] cmd;
        logic [2:0] idx;
        logic       exp_q;
        logic       exp_err;
    } vec_t;
    vec_t tbl [10];

    // Random-phase state
    logic            rv [NREQ];
    logic [1:0]      rc [NREQ];
    logic [2:0]      ri [NREQ];
    logic            mbank [8];
    int              m_cnt, m_ptr, g, c;
    logic            done_now, idle, pend_q, pend_err;
    int              pend_id;
    logic [NREQ-1:0] exp_ready;
    logic [3:0]      oh4;
    logic [NFF-1:0]  oh6;

    initial begin
        tbl[0] = '{0, C_SET,   3'd2, 1'b1, 1'b0};
        tbl[1] = '{1, C_SET,   3'd5, 1'b1, 1'b0};
        tbl[2] = '{1, C_TOG,   3'd5, 1'b0, 1'b0};
        tbl[3] = '{1, C_TOG,   3'd5, 1'b1, 1'b0};
        tbl[4] = '{1, C_HOLD,  3'd5, 1'b1, 1'b0};
        tbl[5] = '{1, C_RESET, 3'd5, 1'b0, 1'b0};
        tbl[6] = '{3, C_SET,   3'd7, 1'b0, 1'b1};
        tbl[7] = '{2, C_TOG,   3'd6, 1'b0, 1'b1};
        tbl[8] = '{2, C_RESET, 3'd2, 1'b0, 1'b0};
        tbl[9] = '{3, C_HOLD,  3'd0, 1'b0, 1'b0};

        // Reset with every requester asserting: nothing may be accepted.
        rst = 1'b1;
        req_valid = '1;
        req_cmd = '0;
        req_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_en", ff_en, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 10; i++)
            run_cmd(tbl[i].r, tbl[i].cmd, tbl[i].idx, tbl[i].exp_q, tbl[i].exp_err);

        // All four requesters held valid: grant order 0,1,2,3,0, one done every 3 cycles.
        req_valid = '1;
        for (int r = 0; r < NREQ; r++) begin
            req_cmd[2*r +: 2] = C_SET;
            req_idx[IDXW*r +: IDXW] = 3'(r);
        end
        for (int i = 0; i < 5; i++) begin
            oh4 = 4'b0001 << (i % 4);
            oh6 = 6'b000001 << (i % 4);
            #1;
            chk("arb_grant", req_ready, oh4);
            @(posedge clk); #1;
            chk("arb_busy_ready", req_ready, 0);
            chk("arb_en", ff_en, oh6);
            @(posedge clk); #1;
            chk("arb_done", done_valid, 1);
            chk("arb_done_id", done_id, i % 4);
            chk("arb_done_q", done_q, 1);
            @(posedge clk);
        end
        #1;
        req_valid = '0;

        // Stuck-at-0 flop: SET must report a readback error.
        stuck_mask = 6'b001000;
        run_cmd(2, C_SET, 3'd3, 1'b0, 1'b1);
        stuck_mask = '0;

        // Reset during APPLY aborts the command without a done pulse.
        req_valid = 4'b0001;
        req_cmd[1:0] = C_SET;
        req_idx[2:0] = 3'd4;
        #1;
        chk("abort_accept", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        chk("abort_apply_en", ff_en, 6'h10);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_en", ff_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_late_done", done_valid, 0);
        chk("abort_idle", busy, 0);

        // Random traffic against a transaction-level model.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0;
        m_ptr = 0;
        pend_id = 0;
        pend_q = 1'b0;
        pend_err = 1'b0;
        for (int i = 0; i < 8; i++) mbank[i] = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            rv[r] = 1'b0;
            rc[r] = '0;
            ri[r] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            done_now = (m_cnt == 1);
            idle     = (m_cnt == 0);
            if (m_cnt > 0) m_cnt--;
            for (int r = 0; r < NREQ; r++) begin
                if (cyc >= 590) rv[r] = 1'b0;
                else if (!rv[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rv[r] = 1'b1;
                        rc[r] = 2'($urandom_range(0, 3));
                        ri[r] = 3'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 19) == 0) rv[r] = 1'b0;
                req_valid[r] = rv[r];
                req_cmd[2*r +: 2] = rc[r];
                req_idx[IDXW*r +: IDXW] = ri[r];
            end
            #1;
            chk("rnd_busy", busy, !idle);
            chk("rnd_done", done_valid, done_now);
            if (done_now) begin
                chk("rnd_done_id", done_id, pend_id);
                chk("rnd_done_q", done_q, pend_q);
                chk("rnd_done_err", done_err, pend_err);
            end
            exp_ready = '0;
            g = -1;
            if (idle) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (g < 0 && rv[c]) g = c;
                end
            end
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                pend_id = g;
                if (ri[g] < NFF) begin
                    pend_q = next_q(rc[g], mbank[ri[g]]);
                    mbank[ri[g]] = pend_q;
                    pend_err = 1'b0;
                    m_cnt = 2;
                end else begin
                    pend_q = 1'b0;
                    pend_err = 1'b1;
                    m_cnt = 1;
                end
                m_ptr = (g + 1) % NREQ;
            end
            chk("rnd_ready", req_ready, exp_ready);
            if (g >= 0) rv[g] = 1'b0;
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
